head_concat_buf: RTL



---
 rtl/head_concat_buf.sv | 109 ++++++++++
 1 files changed

// File: rtl/head_concat_buf.sv
`default_nettype none
// ============================================================================
//  Module      : head_concat_buf
//  Description : Collects per-head attention rows arriving head-major and
//                replays them token-major as concatenated full-width rows.
//  Revision    : 1.0 - initial release
// ============================================================================
module head_concat_buf #(
    parameter int SEQ      = 16,
    parameter int EMB      = 64,
    parameter int HEADS    = 8,
    parameter int HEAD_DIM = EMB / HEADS,
    parameter int DATA_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(HEADS)-1:0]     in_head,
    input  logic [$clog2(SEQ)-1:0]       in_tok,
    input  logic [HEAD_DIM*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(SEQ)-1:0]       out_tok,
    output logic [EMB*DATA_W-1:0]        out_data,
    output logic                         out_last,
    output logic                         seq_err
);

    localparam int c_TW    = $clog2(SEQ);
    localparam int c_HW    = $clog2(HEADS);
    localparam int c_ROW_W = HEAD_DIM * DATA_W;

    localparam logic [c_TW-1:0] c_TOK_LAST  = c_TW'(SEQ - 1);
    localparam logic [c_HW-1:0] c_HEAD_LAST = c_HW'(HEADS - 1);

    localparam logic [0:0] c_ST_FILL  = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

    logic [0:0]      r_state;
    logic [c_TW-1:0] r_wr_tok;
    logic [c_HW-1:0] r_wr_head;
    logic [c_TW-1:0] r_rd_tok;
    logic            r_seq_err;

    logic w_in_fire;
    logic w_out_fire;

    // Handshake outputs are masked by rst so they read idle for the whole
    // reset pulse, not just from the first sampled edge onward.
    assign in_ready   = (r_state == c_ST_FILL)  && !rst;
    assign out_valid  = (r_state == c_ST_DRAIN) && !rst;
    assign out_tok    = rst ? '0 : r_rd_tok;
    assign out_last   = out_valid && (r_rd_tok == c_TOK_LAST);
    assign seq_err    = r_seq_err && !rst;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_FILL;
            r_wr_tok  <= '0;
            r_wr_head <= '0;
            r_rd_tok  <= '0;
            r_seq_err <= 1'b0;
        end else if (r_state == c_ST_FILL) begin
            if (w_in_fire) begin
                // Sender indices are only cross-checked; the counters place the beat.
                if ((in_head != r_wr_head) || (in_tok != r_wr_tok))
                    r_seq_err <= 1'b1;
                if (r_wr_tok == c_TOK_LAST) begin
                    r_wr_tok <= '0;
                    if (r_wr_head == c_HEAD_LAST) begin
                        r_wr_head <= '0;
                        r_state   <= c_ST_DRAIN;
                    end else begin
                        r_wr_head <= r_wr_head + c_HW'(1);
                    end
                end else begin
                    r_wr_tok <= r_wr_tok + c_TW'(1);
                end
            end
        end else begin
            if (w_out_fire) begin
                if (r_rd_tok == c_TOK_LAST) begin
                    r_rd_tok <= '0;
                    r_state  <= c_ST_FILL;
                end else begin
                    r_rd_tok <= r_rd_tok + c_TW'(1);
                end
            end
        end
    end

    // One storage bank per head; each bank supplies its slice of every row.
    for (genvar h = 0; h < HEADS; h++) begin : g_head
        logic [c_ROW_W-1:0] r_mem [SEQ];

        always_ff @(posedge clk) begin
            if (w_in_fire && (r_wr_head == c_HW'(h)))
                r_mem[r_wr_tok] <= in_data;
        end

        assign out_data[h*c_ROW_W +: c_ROW_W] = r_mem[r_rd_tok];
    end

endmodule
`default_nettype wire
